// File: rtl/dp_arb_pkg.sv
// rtl/dp_arb_pkg.sv - shared constants and types for the FIR datapath arbiter
package dp_arb_pkg;

  localparam int OPW_DEF  = 3;
  localparam int REGW_DEF = 4;
  localparam int OP_NOP   = 0;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

endpackage

// File: rtl/dp_arbiter_if.sv
// rtl/dp_arbiter_if.sv - requester/datapath bundle for dp_arbiter
interface dp_arbiter_if
  import dp_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int OPW  = OPW_DEF,
  parameter int REGW = REGW_DEF
);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      last;
  logic [NREQ*OPW-1:0]  op_in;
  logic [NREQ*REGW-1:0] src1_in;
  logic [NREQ*REGW-1:0] src2_in;
  logic [NREQ*REGW-1:0] dest_in;
  logic                 overflow;
  logic [NREQ-1:0]      err_clr;
  logic [NREQ-1:0]      gnt;
  logic [OPW-1:0]       op;
  logic [REGW-1:0]      src1;
  logic [REGW-1:0]      src2;
  logic [REGW-1:0]      dest;
  logic                 busy;
  logic [NREQ-1:0]      err;

  modport master (
    output req, last, op_in, src1_in, src2_in, dest_in, overflow, err_clr,
    input  gnt, op, src1, src2, dest, busy, err
  );

  modport slave (
    input  req, last, op_in, src1_in, src2_in, dest_in, overflow, err_clr,
    output gnt, op, src1, src2, dest, busy, err
  );
endinterface

// File: rtl/dp_arbiter_rr_pick.sv
// rtl/dp_arbiter_rr_pick.sv - cyclic first-requester picker starting at ptr
// Excluded requesters are only chosen when nobody else is asking.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic [NREQ-1:0] exclude,
  output logic [NREQ-1:0] pick,
  output logic            any
);
  logic [NREQ-1:0] cand;
  logic            found;
  int              idx;

  always_comb begin
    cand  = (|(req & ~exclude)) ? (req & ~exclude) : req;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && cand[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    any = found;
  end
endmodule

// File: rtl/dp_arbiter.sv
// rtl/dp_arbiter.sv - round-robin burst arbiter sharing one FIR datapath port
// Optional per-burst op limit: define DP_ARB_TIMEOUT_EN.
module dp_arbiter
  import dp_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int OPW       = OPW_DEF,
  parameter int REGW      = REGW_DEF,
  parameter int MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  dp_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);

  state_t          state, state_nxt;
  logic [NREQ-1:0] gnt, gnt_nxt;
  logic [PW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [PW-1:0]   owner, owner_inc, pick_ptr;
  logic [NREQ-1:0] excl, pick, err_set, err;
  logic            pick_any, owner_req, release_now, timeout_hit;
  logic            op_valid, prev_vld;
  logic [PW-1:0]   prev_owner;
  logic [OPW-1:0]  sel_op;

  always_comb begin
    owner = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) owner = PW'(i);
    end
  end

  assign owner_inc   = (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;
  assign owner_req   = (state == OWN) && bus.req[owner];
  assign release_now = (state == OWN) && (!bus.req[owner] || bus.last[owner] || timeout_hit);
  // On release the search starts just past the owner, so the owner comes last.
  assign pick_ptr    = (state == OWN) ? owner_inc : rr_ptr;
  assign excl        = (state == OWN) ? gnt : '0;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req     (bus.req),
    .ptr     (pick_ptr),
    .exclude (excl),
    .pick    (pick),
    .any     (pick_any)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = OWN;
          gnt_nxt   = pick;
        end
      end
      OWN: begin
        if (release_now) begin
          rr_ptr_nxt = owner_inc;
          if (pick_any) begin
            gnt_nxt = pick;
          end else begin
            gnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    sel_op   = bus.op_in[int'(owner)*OPW +: OPW];
    op_valid = owner_req && (sel_op != OPW'(OP_NOP));
    bus.op   = op_valid ? sel_op : OPW'(OP_NOP);
    bus.src1 = op_valid ? bus.src1_in[int'(owner)*REGW +: REGW] : '0;
    bus.src2 = op_valid ? bus.src2_in[int'(owner)*REGW +: REGW] : '0;
    bus.dest = op_valid ? bus.dest_in[int'(owner)*REGW +: REGW] : '0;
    bus.gnt  = gnt;
    bus.busy = |gnt;
    bus.err  = err;
  end

`ifdef DP_ARB_TIMEOUT_EN
  logic [4:0] burst_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      burst_cnt <= '0;
    end else if (state == IDLE || release_now) begin
      burst_cnt <= '0;
    end else if (owner_req) begin
      burst_cnt <= burst_cnt + 5'd1;
    end
  end

  assign timeout_hit = owner_req && !bus.last[owner] && (burst_cnt == 5'(MAX_BURST - 1));
`else
  assign timeout_hit = (MAX_BURST < 0);
`endif

  // Overflow always refers to the op issued one cycle earlier.
  always_comb begin
    err_set = '0;
    if (bus.overflow && prev_vld) err_set[prev_owner] = 1'b1;
    if (timeout_hit) err_set[owner] = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_vld   <= 1'b0;
      prev_owner <= '0;
      err        <= '0;
    end else begin
      prev_vld   <= op_valid;
      prev_owner <= owner;
      err        <= (err & ~bus.err_clr) | err_set;
    end
  end
endmodule
